// File: rtl/aq_iu_vsetvl_req.sv
// aq_iu_vsetvl_req: IU-side initiator for vsetvl/vsetvli.
// Captures the EX1 operands and sends a one-cycle request to the CP0 special
// unit. It then waits for the completion and the new vl, and writes that value
// back through the RTU writeback port. If CP0 never answers, a response timeout
// forces completion with vl = 0 so the pipeline cannot hang.
module aq_iu_vsetvl_req #(
  parameter int RSP_TIMEOUT = 16,  // WAIT cycles before forced completion (>= 2)
  parameter int CNT_W       = 5    // must hold RSP_TIMEOUT-1
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  input  logic        ex1_vsetvl_vld,
  input  logic        ex1_vsetvl_dp,
  input  logic [63:0] ex1_rs1,
  input  logic [11:0] ex1_vtype,
  input  logic        ex1_rs1_x0,
  input  logic        ex1_rd_x0,
  input  logic [4:0]  ex1_rd_idx,
  input  logic        rtu_iu_flush,
  output logic        iu_ex1_vsetvl_stall,
  output logic        iu_ex1_vsetvl_done,
  output logic        iui_special_vsetvl,
  output logic        iui_special_vsetvl_dp,
  output logic [63:0] iui_special_vsetvl_rs1,
  output logic [11:0] iui_special_vsetvl_rs2,
  output logic        iui_special_rs1_x0,
  input  logic        special_iui_vsetvl_cmplt,
  input  logic [63:0] special_iui_vsetvl_wdata,
  output logic        iu_rtu_wb_vld,
  output logic [4:0]  iu_rtu_wb_idx,
  output logic [63:0] iu_rtu_wb_data,
  input  logic        rtu_iu_wb_grant,
  output logic        iu_vsetvl_busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] WB   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             dp_q;
  logic [63:0]      rs1_q;
  logic [11:0]      vtype_q;
  logic             rs1_x0_q;
  logic             rd_x0_q;
  logic [4:0]       rd_idx_q;
  logic [63:0]      data_q;

  // Sequencer: capture in IDLE, request, wait (with timeout), write back.
  // NOTE: every register here uses non-blocking assignment. That way each
  // branch reads the pre-edge values, regardless of the order of statements.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      // NOTE: the operand and data registers are cleared along with the
      // state. They drive outputs directly, and those outputs must read 0
      // after reset.
      state    <= IDLE;
      cnt      <= '0;
      dp_q     <= 1'b0;
      rs1_q    <= '0;
      vtype_q  <= '0;
      rs1_x0_q <= 1'b0;
      rd_x0_q  <= 1'b0;
      rd_idx_q <= '0;
      data_q   <= '0;
    end else if (rtu_iu_flush) begin
      // A flush abandons any transaction. Any response that arrives later
      // lands in IDLE and is ignored.
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ex1_vsetvl_vld) begin
            dp_q     <= ex1_vsetvl_dp;
            rs1_q    <= ex1_rs1;
            vtype_q  <= ex1_vtype;
            rs1_x0_q <= ex1_rs1_x0;
            rd_x0_q  <= ex1_rd_x0;
            rd_idx_q <= ex1_rd_idx;
            state    <= REQ;
          end
        end
        REQ: begin
          if (special_iui_vsetvl_cmplt) begin
            data_q <= special_iui_vsetvl_wdata;
            state  <= WB;
          end else begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          // If the completion arrives in the timeout cycle, the completion
          // takes priority and its data is used.
          if (special_iui_vsetvl_cmplt) begin
            data_q <= special_iui_vsetvl_wdata;
            state  <= WB;
          end else if (cnt == CNT_LAST) begin
            data_q <= '0;
            state  <= WB;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WB: begin
          if (rd_x0_q || rtu_iu_wb_grant) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode. While reset is asserted, every output is forced to 0.
  always_comb begin
    iui_special_vsetvl     = !cpurst && (state == REQ);
    iu_vsetvl_busy         = !cpurst && (state != IDLE);
    iu_rtu_wb_vld          = !cpurst && !rtu_iu_flush && (state == WB) && !rd_x0_q;
    iu_ex1_vsetvl_done     = !cpurst && !rtu_iu_flush && (state == WB) &&
                             (rd_x0_q || rtu_iu_wb_grant);
    iu_ex1_vsetvl_stall    = !cpurst && ex1_vsetvl_vld && !iu_ex1_vsetvl_done;
    iui_special_vsetvl_dp  = !cpurst && dp_q;
    iui_special_vsetvl_rs1 = cpurst ? 64'd0 : rs1_q;
    iui_special_vsetvl_rs2 = cpurst ? 12'd0 : vtype_q;
    iui_special_rs1_x0     = !cpurst && rs1_x0_q;
    iu_rtu_wb_idx          = cpurst ? 5'd0 : rd_idx_q;
    iu_rtu_wb_data         = cpurst ? 64'd0 : data_q;
  end

endmodule

// File: tb/tb_aq_iu_vsetvl_req.sv
// tb_aq_iu_vsetvl_req: self-checking bench for aq_iu_vsetvl_req.
// Each transaction is described by a few parameters: response delay, grant
// delay, flush cycle and reset cycle. The bench derives the expected output
// timeline from those parameters. A negedge compare process checks every
// output against that timeline on each cycle. Directed cases also pin
// latencies and data to hand-computed literals.
module tb_aq_iu_vsetvl_req;

  localparam int TO = 16;

  logic        forever_cpuclk = 1'b0;
  logic        cpurst;
  logic        ex1_vsetvl_vld, ex1_vsetvl_dp, ex1_rs1_x0, ex1_rd_x0;
  logic [63:0] ex1_rs1;
  logic [11:0] ex1_vtype;
  logic [4:0]  ex1_rd_idx;
  logic        rtu_iu_flush;
  logic        iu_ex1_vsetvl_stall, iu_ex1_vsetvl_done;
  logic        iui_special_vsetvl, iui_special_vsetvl_dp, iui_special_rs1_x0;
  logic [63:0] iui_special_vsetvl_rs1;
  logic [11:0] iui_special_vsetvl_rs2;
  logic        special_iui_vsetvl_cmplt;
  logic [63:0] special_iui_vsetvl_wdata;
  logic        iu_rtu_wb_vld;
  logic [4:0]  iu_rtu_wb_idx;
  logic [63:0] iu_rtu_wb_data;
  logic        rtu_iu_wb_grant;
  logic        iu_vsetvl_busy;

  aq_iu_vsetvl_req #(.RSP_TIMEOUT(TO), .CNT_W(5)) dut (
    .forever_cpuclk          (forever_cpuclk),
    .cpurst                  (cpurst),
    .ex1_vsetvl_vld          (ex1_vsetvl_vld),
    .ex1_vsetvl_dp           (ex1_vsetvl_dp),
    .ex1_rs1                 (ex1_rs1),
    .ex1_vtype               (ex1_vtype),
    .ex1_rs1_x0              (ex1_rs1_x0),
    .ex1_rd_x0               (ex1_rd_x0),
    .ex1_rd_idx              (ex1_rd_idx),
    .rtu_iu_flush            (rtu_iu_flush),
    .iu_ex1_vsetvl_stall     (iu_ex1_vsetvl_stall),
    .iu_ex1_vsetvl_done      (iu_ex1_vsetvl_done),
    .iui_special_vsetvl      (iui_special_vsetvl),
    .iui_special_vsetvl_dp   (iui_special_vsetvl_dp),
    .iui_special_vsetvl_rs1  (iui_special_vsetvl_rs1),
    .iui_special_vsetvl_rs2  (iui_special_vsetvl_rs2),
    .iui_special_rs1_x0      (iui_special_rs1_x0),
    .special_iui_vsetvl_cmplt(special_iui_vsetvl_cmplt),
    .special_iui_vsetvl_wdata(special_iui_vsetvl_wdata),
    .iu_rtu_wb_vld           (iu_rtu_wb_vld),
    .iu_rtu_wb_idx           (iu_rtu_wb_idx),
    .iu_rtu_wb_data          (iu_rtu_wb_data),
    .rtu_iu_wb_grant         (rtu_iu_wb_grant),
    .iu_vsetvl_busy          (iu_vsetvl_busy)
  );

  always #5 forever_cpuclk = ~forever_cpuclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected values for the current cycle.
  bit          exp_on = 1'b0;
  bit          exp_zero;
  bit          exp_stall, exp_done, exp_req, exp_busy, exp_wb_vld;
  logic [4:0]  exp_idx;
  logic [63:0] exp_data;
  // Operand values last sent to CP0. They are zero after reset.
  bit          m_dp, m_rs1_x0;
  logic [63:0] m_rs1;
  logic [11:0] m_vtype;

  // Per-transaction observations, used by the directed literal pins.
  int          o_req_n, o_req_k, o_done_n, o_done_k, o_wb_n, o_first_wb;
  logic [63:0] o_req_rs1, o_wb_data;
  logic [11:0] o_req_rs2;

  // Compare process: all outputs are checked at every falling edge.
  always @(negedge forever_cpuclk) begin
    if (exp_on) begin
      if (exp_zero) begin
        check("rst_stall", iu_ex1_vsetvl_stall, 0);
        check("rst_done", iu_ex1_vsetvl_done, 0);
        check("rst_req", iui_special_vsetvl, 0);
        check("rst_busy", iu_vsetvl_busy, 0);
        check("rst_wb_vld", iu_rtu_wb_vld, 0);
        check("rst_dp", iui_special_vsetvl_dp, 0);
        check("rst_rs1", iui_special_vsetvl_rs1, 0);
        check("rst_rs2", iui_special_vsetvl_rs2, 0);
        check("rst_rs1_x0", iui_special_rs1_x0, 0);
        check("rst_wb_idx", iu_rtu_wb_idx, 0);
        check("rst_wb_data", iu_rtu_wb_data, 0);
      end else begin
        check("stall", iu_ex1_vsetvl_stall, exp_stall);
        check("done", iu_ex1_vsetvl_done, exp_done);
        check("req", iui_special_vsetvl, exp_req);
        check("busy", iu_vsetvl_busy, exp_busy);
        check("wb_vld", iu_rtu_wb_vld, exp_wb_vld);
        check("op_dp", iui_special_vsetvl_dp, m_dp);
        check("op_rs1", iui_special_vsetvl_rs1, m_rs1);
        check("op_rs2", iui_special_vsetvl_rs2, m_vtype);
        check("op_rs1_x0", iui_special_rs1_x0, m_rs1_x0);
        if (exp_wb_vld) begin
          check("wb_idx", iu_rtu_wb_idx, exp_idx);
          check("wb_data", iu_rtu_wb_data, exp_data);
        end
      end
    end
  end

  task automatic step();
    @(posedge forever_cpuclk);
    #1;
  endtask

  // One cycle with no instruction being captured. If vld is set, flush must
  // be set as well, so the flush blocks the capture.
  task automatic gap(input bit vld, input bit fl, input bit rst, input bit late_cmplt);
    step();
    cpurst                   = rst;
    ex1_vsetvl_vld           = vld;
    rtu_iu_flush             = fl;
    ex1_rs1                  = {$urandom, $urandom};
    ex1_vtype                = 12'($urandom);
    ex1_rd_idx               = 5'($urandom);
    special_iui_vsetvl_cmplt = late_cmplt | 1'($urandom);
    special_iui_vsetvl_wdata = {$urandom, $urandom};
    rtu_iu_wb_grant          = 1'($urandom);
    exp_zero   = rst;
    exp_stall  = vld;
    exp_done   = 0;
    exp_req    = 0;
    exp_busy   = 0;
    exp_wb_vld = 0;
    exp_on     = 1;
    if (rst) begin
      m_dp = 0; m_rs1 = 0; m_vtype = 0; m_rs1_x0 = 0;
    end
  endtask

  // One instruction. cd is the response delay in cycles after REQ
  // (0..TO responds; > TO never responds). gd is the grant delay after
  // WB entry. flush_k and rst_k give the cycle, relative to capture, of a
  // flush or reset (-1 for none).
  task automatic run_txn(input bit dp, input logic [63:0] rs1, input logic [11:0] vtype,
                         input bit rs1_x0, input bit rd_x0, input logic [4:0] idx,
                         input int cd, input logic [63:0] wdata, input int gd,
                         input int flush_k, input int rst_k);
    int          resp_k, wb_k, end_k;
    bit          in_rng, fl, rs, in_wb;
    logic [63:0] dexp;
    in_rng = (cd >= 0) && (cd <= TO);
    resp_k = in_rng ? 1 + cd : -1;
    wb_k   = in_rng ? 2 + cd : 2 + TO;
    dexp   = in_rng ? wdata : 64'd0;
    end_k  = rd_x0 ? wb_k : wb_k + gd;
    o_req_n = 0; o_req_k = -1; o_done_n = 0; o_done_k = -1; o_wb_n = 0; o_first_wb = -1;
    o_req_rs1 = 0; o_req_rs2 = 0; o_wb_data = 0;
    for (int k = 0; k <= end_k; k++) begin
      step();
      fl = (k == flush_k);
      rs = (k == rst_k);
      in_wb = (k >= wb_k);
      cpurst         = rs;
      rtu_iu_flush   = fl;
      ex1_vsetvl_vld = 1;
      ex1_vsetvl_dp  = dp;
      ex1_rs1        = rs1;
      ex1_vtype      = vtype;
      ex1_rs1_x0     = rs1_x0;
      ex1_rd_x0      = rd_x0;
      ex1_rd_idx     = idx;
      if (k == resp_k) begin
        special_iui_vsetvl_cmplt = 1;
        special_iui_vsetvl_wdata = wdata;
      end else begin
        // A completion must not be seen in REQ/WAIT except at the response
        // cycle. In IDLE and WB, random noise must be ignored.
        special_iui_vsetvl_cmplt = (k == 0 || in_wb) ? 1'($urandom) : 1'b0;
        special_iui_vsetvl_wdata = {$urandom, $urandom};
      end
      if (in_wb && !rd_x0) rtu_iu_wb_grant = (k == wb_k + gd);
      else                 rtu_iu_wb_grant = 1'($urandom);
      if (k == 1) begin
        m_dp = dp; m_rs1 = rs1; m_vtype = vtype; m_rs1_x0 = rs1_x0;
      end
      exp_zero   = rs;
      exp_busy   = (k >= 1);
      exp_req    = (k == 1);
      exp_wb_vld = in_wb && !rd_x0 && !fl;
      exp_done   = in_wb && (rd_x0 || (k == wb_k + gd)) && !fl;
      exp_stall  = !exp_done;
      exp_idx    = idx;
      exp_data   = dexp;
      exp_on     = 1;
      #1;
      if (iui_special_vsetvl) begin
        o_req_n++;
        if (o_req_k < 0) begin
          o_req_k = k; o_req_rs1 = iui_special_vsetvl_rs1; o_req_rs2 = iui_special_vsetvl_rs2;
        end
      end
      if (iu_ex1_vsetvl_done) begin o_done_n++; o_done_k = k; end
      if (iu_rtu_wb_vld) begin
        o_wb_n++;
        if (o_first_wb < 0) begin o_first_wb = k; o_wb_data = iu_rtu_wb_data; end
      end
      if (fl) break;
      if (rs) begin
        m_dp = 0; m_rs1 = 0; m_vtype = 0; m_rs1_x0 = 0;
        break;
      end
    end
  endtask

  initial begin
    cpurst = 1; ex1_vsetvl_vld = 0; ex1_vsetvl_dp = 0; ex1_rs1 = 0; ex1_vtype = 0;
    ex1_rs1_x0 = 0; ex1_rd_x0 = 0; ex1_rd_idx = 0; rtu_iu_flush = 0;
    special_iui_vsetvl_cmplt = 0; special_iui_vsetvl_wdata = 0; rtu_iu_wb_grant = 0;
    m_dp = 0; m_rs1 = 0; m_vtype = 0; m_rs1_x0 = 0;

    // Reset: all outputs are 0 during and after reset.
    gap(0, 0, 1, 0);
    gap(0, 0, 1, 0);
    gap(0, 0, 0, 0);

    // 1. Basic: cmplt 3 cycles after REQ, grant in the same cycle.
    run_txn(1, 64'h40, 12'h0D3, 0, 0, 5'd5, 3, 64'h10, 0, -1, -1);
    check("t1_req_k", o_req_k, 1);
    check("t1_req_n", o_req_n, 1);
    check("t1_req_rs1", o_req_rs1, 64'h40);
    check("t1_req_rs2", o_req_rs2, 12'h0D3);
    check("t1_wb_data", o_wb_data, 64'h10);
    check("t1_done_n", o_done_n, 1);
    gap(0, 0, 0, 0);

    // 2. CP0 never answers: WB at T+18 with data 0, done after grant.
    run_txn(0, 64'h7, 12'h011, 0, 0, 5'd9, TO + 1, 64'hDEAD, 2, -1, -1);
    check("t2_first_wb", o_first_wb, 18);
    check("t2_wb_data", o_wb_data, 0);
    check("t2_done_k", o_done_k, 20);

    // 3. rd = x0, completion in the REQ cycle: done at T+2, no writeback.
    run_txn(0, 64'h3, 12'h0C0, 1, 1, 5'd0, 0, 64'h8, 0, -1, -1);
    check("t3_done_k", o_done_k, 2);
    check("t3_wb_n", o_wb_n, 0);

    // 4. Grant withheld for 5 cycles.
    run_txn(1, 64'h99, 12'h0D0, 0, 0, 5'd17, 1, 64'h55, 5, -1, -1);
    check("t4_wb_n", o_wb_n, 6);
    check("t4_done_n", o_done_n, 1);
    check("t4_done_k", o_done_k, 8);

    // 5. Flush in WAIT, then a late completion: no effect. Next vld runs normally.
    run_txn(1, 64'h21, 12'h0D1, 0, 0, 5'd3, 4, 64'h77, 0, 3, -1);
    check("t5_done_n", o_done_n, 0);
    check("t5_wb_n", o_wb_n, 0);
    gap(0, 0, 0, 0);
    gap(0, 0, 0, 1);
    gap(1, 1, 0, 0);  // a flush in IDLE blocks capture
    run_txn(0, 64'h22, 12'h0D2, 0, 0, 5'd4, 2, 64'h12, 1, -1, -1);
    check("t5_next_done_n", o_done_n, 1);

    // 6a. Completion in the timeout cycle wins.
    run_txn(0, 64'h30, 12'h0D4, 0, 0, 5'd6, TO, 64'h20, 0, -1, -1);
    check("t6_first_wb", o_first_wb, 18);
    check("t6_wb_data", o_wb_data, 64'h20);

    // 6b. Reset during WB: transaction abandoned, everything reads 0.
    run_txn(1, 64'h31, 12'h0D5, 1, 0, 5'd7, 1, 64'h44, 3, -1, 4);
    check("t6b_done_n", o_done_n, 0);
    gap(0, 0, 0, 0);
    exp_zero = 1;
    @(negedge forever_cpuclk);
    exp_zero = 0;
    run_txn(0, 64'h32, 12'h0D6, 0, 0, 5'd8, 0, 64'h9, 0, -1, -1);
    check("t6b_next_done_n", o_done_n, 1);

    // Randomized back-to-back traffic.
    for (int n = 0; n < 200; n++) begin
      int r, cd, fk;
      r  = $urandom_range(0, 9);
      cd = (r < 5) ? $urandom_range(0, 4) : (r < 7) ? TO - 1 + $urandom_range(0, 1) : TO + 1;
      fk = ($urandom_range(0, 9) == 0) ? $urandom_range(1, TO + 5) : -1;
      run_txn(1'($urandom), {$urandom, $urandom}, 12'($urandom), 1'($urandom),
              ($urandom_range(0, 3) == 0), 5'($urandom), cd, {$urandom, $urandom},
              $urandom_range(0, 3), fk, -1);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        if ($urandom_range(0, 1) == 1) gap(1, 1, 0, 0);
        else                           gap(0, 0, 0, 0);
      end
    end

    step();
    exp_on = 0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/aq_iu_vsetvl_req.md
Name: aq_iu_vsetvl_req

Overview:
IU-side initiator for vsetvl/vsetvli. It captures EX1 operands, issues a single-cycle request on the iui_special_vsetvl interface to the CP0 special unit, and waits for the completion and returned vl (wdata). It then writes the result back through the RTU writeback port. A response timeout is included so the pipeline cannot hang when CP0 vector support is stubbed and never answers.

Parameters:
RSP_TIMEOUT, 16, number of WAIT cycles without completion before forced completion with wdata 0 (>=2)
CNT_W, 5, width of the timeout counter (must hold RSP_TIMEOUT-1)

Ports:
forever_cpuclk  in  1  clock
cpurst  in  1  reset; synchronous, active-high
ex1_vsetvl_vld  in  1  vsetvl instruction valid in EX1 (held while stalled)
ex1_vsetvl_dp  in  1  1=vsetvl (rs2 from register), 0=vsetvli (immediate)
ex1_rs1  in  64  AVL operand
ex1_vtype  in  12  vtype operand
ex1_rs1_x0  in  1  rs1 field is x0
ex1_rd_x0  in  1  rd field is x0
ex1_rd_idx  in  5  destination register index
rtu_iu_flush  in  1  pipeline flush
iu_ex1_vsetvl_stall  out  1  hold EX1
iu_ex1_vsetvl_done  out  1  single-cycle retire pulse
iui_special_vsetvl  out  1  request pulse to CP0
iui_special_vsetvl_dp  out  1  registered dp
iui_special_vsetvl_rs1  out  64  registered rs1
iui_special_vsetvl_rs2  out  12  registered vtype
iui_special_rs1_x0  out  1  registered rs1_x0
special_iui_vsetvl_cmplt  in  1  CP0 completion
special_iui_vsetvl_wdata  in  64  new vl value; valid with cmplt
iu_rtu_wb_vld  out  1  writeback request
iu_rtu_wb_idx  out  5  writeback register
iu_rtu_wb_data  out  64  writeback data
rtu_iu_wb_grant  in  1  writeback accepted
iu_vsetvl_busy  out  1  state != IDLE

Behaviour:
- Reset (cpurst=1 at a clock edge) forces state IDLE, counter 0, and all operand/data registers 0. All outputs are 0 during and after reset. Reset mid-operation abandons the transaction with no done pulse and no writeback.
- FSM states: IDLE, REQ, WAIT, WB.
- IDLE: if ex1_vsetvl_vld & !rtu_iu_flush, capture dp/rs1/vtype/rs1_x0/rd_x0/rd_idx and go to REQ. Cycle T = capture, REQ at T+1.
- REQ: iui_special_vsetvl=1 for exactly this cycle.
  - If cmplt is also high in this cycle, latch wdata and go to WB.
  - Otherwise go to WAIT with counter=0.
- WAIT:
  - cmplt: latch wdata and go to WB.
  - No cmplt and counter==RSP_TIMEOUT-1: latch data=0 and go to WB.
  - Otherwise counter+1.
  - cmplt and timeout in the same cycle: cmplt wins and its data is used.
  - With no response, WB is entered at T+2+RSP_TIMEOUT.
- cmplt is ignored in IDLE and WB. A late response after a flush has no effect.
- WB, rd_x0=1: done=1 for one cycle, wb_vld stays 0, next state IDLE.
- WB, rd_x0=0: wb_vld=1 with idx/data held stable until grant. On grant, done=1 and next state IDLE.
- iu_ex1_vsetvl_stall = ex1_vsetvl_vld & !iu_ex1_vsetvl_done (combinational). EX1 advances the cycle after done, so a vld in that IDLE cycle is a new instruction.
- iui_special_vsetvl_* operand outputs come from registers. They are stable from REQ through WB and retain their last value in IDLE.
- rtu_iu_flush in any state: next state IDLE, counter 0. In the flush cycle, wb_vld and done are gated to 0, and grant that cycle is ignored. A flush in IDLE blocks capture.
- Back-to-back instructions: minimum three cycles per instruction (IDLE capture, REQ with same-cycle cmplt, WB with same-cycle grant).

Test Plan:
1. Basic: vld, rs1=0x40, vtype=0x0D3, rd=5, dp=1. cmplt 3 cycles after REQ with wdata=0x10, grant same cycle -> req pulse at T+1 with rs1=0x40/rs2=0x0D3; wb_vld idx=5 data=0x10; done pulse once; stall drops.
2. Stub CP0 (cmplt tied 0), RSP_TIMEOUT=16 -> WB entered at T+18, wb_data=0, done after grant.
3. rd_x0=1, cmplt in REQ cycle with wdata=0x8 -> done at T+2, wb_vld never asserted.
4. grant withheld 5 cycles -> wb_vld/idx/data constant for 5 cycles, stall=1, busy=1; done on the grant cycle only.
5. flush in WAIT, then cmplt 2 cycles later -> IDLE, no wb_vld, no done; next vld is processed normally.
6. cmplt in the timeout cycle with wdata=0x20 -> wb_data=0x20. Separately, cpurst during WB -> all outputs 0 the next cycle, state IDLE.
